// File: rtl/if_ctrl.sv
// ---------------------------------------------------------------------------
// if_ctrl -- IF-stage front-end controller
//
// Merges the ID hazard and MEM stall into the IF freeze. Captures taken
// branches from EXE and turns each one into a redirect: one cycle of
// branchTaken, followed by flush for a fixed number of unfrozen cycles.
// A redirect that arrives while memory is busy is parked in HOLD until the
// stall clears. Two performance counters are also provided.
//
// Parameters
//   FLUSH_CYCLES      unfrozen cycles flush stays high per redirect (1..15)
// Ports
//   clk               clock, rising edge
//   rst               synchronous reset, active low
//   hazard            ID-stage data hazard (level)
//   mem_busy          memory-stage stall (level)
//   exe_branch_taken  branch resolved taken in EXE
//   exe_branch_addr   target of that branch
//   freeze            IF stall (combinational)
//   flush             IF/ID flush (registered)
//   branchTaken       IF PC redirect (registered)
//   branchAddr        redirect target (registered)
//   stall_cycles      cycles with freeze=1, saturating at 0xFFFF
//   branch_count      redirects issued, wrapping
// ---------------------------------------------------------------------------
module if_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard,
  input  logic        mem_busy,
  input  logic        exe_branch_taken,
  input  logic [31:0] exe_branch_addr,
  output logic        freeze,
  output logic        flush,
  output logic        branchTaken,
  output logic [31:0] branchAddr,
  output logic [15:0] stall_cycles,
  output logic [15:0] branch_count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_HOLD     = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_FLUSH    = 2'd3
  } state_t;

  localparam logic [3:0] FCNT_INIT = 4'(FLUSH_CYCLES);

  state_t      state_r;
  logic [3:0]  fcnt_r;
  logic        flush_r;
  logic        taken_r;
  logic [31:0] addr_r;
  logic [15:0] stall_cnt_r;
  logic [15:0] branch_cnt_r;
  logic        freeze_s;

  // Freeze: a hazard is moot while the wrong path is being flushed, but a
  // memory stall always freezes IF.
  always_comb begin
    freeze_s = mem_busy | (hazard & ~flush_r);
  end

  // Controller state, flush counter, registered outputs and counters.
  // flush_r/taken_r are loaded together with the next state so that they
  // equal (state==REDIRECT|FLUSH) and (state==REDIRECT) in every cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= ST_RUN;
      fcnt_r       <= 4'd0;
      flush_r      <= 1'b0;
      taken_r      <= 1'b0;
      addr_r       <= 32'd0;
      stall_cnt_r  <= 16'd0;
      branch_cnt_r <= 16'd0;
    end else begin
      if (freeze_s && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'd1;
      end

      case (state_r)
        ST_RUN: begin
          // Only a branch seen in RUN is on the correct path.
          if (exe_branch_taken) begin
            addr_r <= exe_branch_addr;
            fcnt_r <= FCNT_INIT;
            if (mem_busy) begin
              state_r <= ST_HOLD;
            end else begin
              state_r      <= ST_REDIRECT;
              flush_r      <= 1'b1;
              taken_r      <= 1'b1;
              branch_cnt_r <= branch_cnt_r + 16'd1;
            end
          end
        end

        ST_HOLD: begin
          // EXE is frozen and keeps re-presenting the same branch; ignore it.
          if (!mem_busy) begin
            state_r      <= ST_REDIRECT;
            flush_r      <= 1'b1;
            taken_r      <= 1'b1;
            branch_cnt_r <= branch_cnt_r + 16'd1;
          end
        end

        ST_REDIRECT: begin
          // The redirect cycle is the first of the FLUSH_CYCLES flush cycles.
          if (!mem_busy) begin
            fcnt_r  <= fcnt_r - 4'd1;
            taken_r <= 1'b0;
            if (fcnt_r == 4'd1) begin
              state_r <= ST_RUN;
              flush_r <= 1'b0;
            end else begin
              state_r <= ST_FLUSH;
            end
          end
        end

        ST_FLUSH: begin
          if (!mem_busy) begin
            fcnt_r <= fcnt_r - 4'd1;
            if (fcnt_r == 4'd1) begin
              state_r <= ST_RUN;
              flush_r <= 1'b0;
            end
          end
        end

        default: begin
          state_r <= ST_RUN;
          fcnt_r  <= 4'd0;
          flush_r <= 1'b0;
          taken_r <= 1'b0;
        end
      endcase
    end
  end

  assign freeze       = freeze_s;
  assign flush        = flush_r;
  assign branchTaken  = taken_r;
  assign branchAddr   = addr_r;
  assign stall_cycles = stall_cnt_r;
  assign branch_count = branch_cnt_r;

endmodule

// File: tb/tb_if_ctrl.sv
// ---------------------------------------------------------------------------
// tb_if_ctrl -- self-checking bench for if_ctrl
//
// Two instances share all inputs: FLUSH_CYCLES=2 (index 0) and
// FLUSH_CYCLES=1 (index 1). Each is tracked by a reference model that
// only remembers "redirect waiting for memory", "flush cycles still owed",
// the captured target and the two counts.
// ---------------------------------------------------------------------------
module tb_if_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        hazard;
  logic        mem_busy;
  logic        exe_branch_taken;
  logic [31:0] exe_branch_addr;

  logic        frz_o   [2];
  logic        flush_o [2];
  logic        taken_o [2];
  logic [31:0] addr_o  [2];
  logic [15:0] sc_o    [2];
  logic [15:0] bc_o    [2];

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int          fc     [2];
  int          m_left [2];  // unfrozen flush cycles still owed
  bit          m_wait [2];  // redirect captured, waiting for mem_busy=0
  logic [31:0] m_addr [2];
  int          m_sc   [2];
  int          m_bc   [2];

  always #5 clk = ~clk;

  if_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .hazard(hazard), .mem_busy(mem_busy),
    .exe_branch_taken(exe_branch_taken), .exe_branch_addr(exe_branch_addr),
    .freeze(frz_o[0]), .flush(flush_o[0]), .branchTaken(taken_o[0]),
    .branchAddr(addr_o[0]), .stall_cycles(sc_o[0]), .branch_count(bc_o[0])
  );

  if_ctrl #(.FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .hazard(hazard), .mem_busy(mem_busy),
    .exe_branch_taken(exe_branch_taken), .exe_branch_addr(exe_branch_addr),
    .freeze(frz_o[1]), .flush(flush_o[1]), .branchTaken(taken_o[1]),
    .branchAddr(addr_o[1]), .stall_cycles(sc_o[1]), .branch_count(bc_o[1])
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit exp_flush(input int i);
    return m_left[i] > 0;
  endfunction

  function automatic bit exp_taken(input int i);
    return m_left[i] == fc[i];
  endfunction

  function automatic bit exp_freeze(input int i);
    return mem_busy | (hazard & ~exp_flush(i));
  endfunction

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      check_val($sformatf("freeze[%0d]", i), {31'd0, frz_o[i]},   {31'd0, exp_freeze(i)});
      check_val($sformatf("flush[%0d]", i),  {31'd0, flush_o[i]}, {31'd0, exp_flush(i)});
      check_val($sformatf("taken[%0d]", i),  {31'd0, taken_o[i]}, {31'd0, exp_taken(i)});
      check_val($sformatf("addr[%0d]", i),   addr_o[i],           m_addr[i]);
      check_val($sformatf("stall_cnt[%0d]", i),  {16'd0, sc_o[i]}, 32'(m_sc[i]));
      check_val($sformatf("branch_cnt[%0d]", i), {16'd0, bc_o[i]}, 32'(m_bc[i]));
    end
  endtask

  // Apply one rising edge to the model, using the inputs present at that edge.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      bit frz;
      frz = exp_freeze(i);
      if (!rst) begin
        m_left[i] = 0;
        m_wait[i] = 1'b0;
        m_addr[i] = 32'd0;
        m_sc[i]   = 0;
        m_bc[i]   = 0;
      end else begin
        if (frz && m_sc[i] < 65535) m_sc[i]++;
        if (m_left[i] > 0) begin
          if (!mem_busy) m_left[i]--;
        end else if (m_wait[i]) begin
          if (!mem_busy) begin
            m_wait[i] = 1'b0;
            m_left[i] = fc[i];
            m_bc[i]   = (m_bc[i] + 1) % 65536;
          end
        end else if (exe_branch_taken) begin
          m_addr[i] = exe_branch_addr;
          if (mem_busy) begin
            m_wait[i] = 1'b1;
          end else begin
            m_left[i] = fc[i];
            m_bc[i]   = (m_bc[i] + 1) % 65536;
          end
        end
      end
    end
  endtask

  // One clock: drive inputs at negedge, optionally compare, then take the edge.
  task automatic cyc(input bit r, input bit h, input bit m, input bit b,
                     input logic [31:0] a, input bit chk);
    @(negedge clk);
    rst              = r;
    hazard           = h;
    mem_busy         = m;
    exe_branch_taken = b;
    exe_branch_addr  = a;
    #1;
    if (chk) check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    int sat_extra;
    fc[0] = 2;
    fc[1] = 1;
    for (int i = 0; i < 2; i++) begin
      m_left[i] = 0; m_wait[i] = 1'b0; m_addr[i] = 32'd0; m_sc[i] = 0; m_bc[i] = 0;
    end
    rst = 1'b0; hazard = 1'b0; mem_busy = 1'b0;
    exe_branch_taken = 1'b0; exe_branch_addr = 32'd0;

    // reset with random inputs
    cyc(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), $urandom, 1'b0);
    cyc(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), $urandom, 1'b1);
    check_val("rst_flush",  {31'd0, flush_o[0]}, 32'd0);
    check_val("rst_taken",  {31'd0, taken_o[0]}, 32'd0);
    check_val("rst_addr",   addr_o[0], 32'd0);
    check_val("rst_stall",  {16'd0, sc_o[0]}, 32'd0);
    check_val("rst_branch", {16'd0, bc_o[0]}, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

    // plain branch
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0008, 1'b1);
    check_val("pb_taken_n1", {31'd0, taken_o[0]}, 32'd1);
    check_val("pb_addr_n1",  addr_o[0], 32'h0000_0008);
    check_val("pb_flush_n1", {31'd0, flush_o[0]}, 32'd1);
    check_val("pb_fc1_taken_n1", {31'd0, taken_o[1]}, 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    check_val("pb_taken_n2", {31'd0, taken_o[0]}, 32'd0);
    check_val("pb_flush_n2", {31'd0, flush_o[0]}, 32'd1);
    check_val("pb_fc1_flush_n2", {31'd0, flush_o[1]}, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    check_val("pb_flush_n3", {31'd0, flush_o[0]}, 32'd0);
    check_val("pb_count",    {16'd0, bc_o[0]}, 32'd1);

    // branch under a 3-cycle memory stall
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b1);
    for (int k = 0; k < 3; k++) begin
      check_val("st_taken_lo", {31'd0, taken_o[0]}, 32'd0);
      check_val("st_freeze",   {31'd0, frz_o[0]}, 32'd1);
      if (k < 2) cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    check_val("st_taken_hi", {31'd0, taken_o[0]}, 32'd1);
    check_val("st_addr",     addr_o[0], 32'h0000_0100);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'hDEAD_0000, 1'b1);
    check_val("st_taken_held", {31'd0, taken_o[0]}, 32'd1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    check_val("st_taken_held2", {31'd0, taken_o[0]}, 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    check_val("st_taken_drop", {31'd0, taken_o[0]}, 32'd0);
    check_val("st_flush_on",   {31'd0, flush_o[0]}, 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    check_val("st_flush_off",  {31'd0, flush_o[0]}, 32'd0);

    // hazard masking
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    check_val("hz_run_freeze", {31'd0, frz_o[0]}, 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0040, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    check_val("hz_flush_freeze", {31'd0, frz_o[0]}, 32'd0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
    check_val("hz_busy_freeze", {31'd0, frz_o[0]}, 32'd1);
    check_val("hz_busy_flush",  {31'd0, flush_o[0]}, 32'd1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
    check_val("hz_busy_flush2", {31'd0, flush_o[0]}, 32'd1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    check_val("hz_flush_done",  {31'd0, flush_o[0]}, 32'd0);
    check_val("hz_unmasked",    {31'd0, frz_o[0]}, 32'd1);

    // reset in the middle of a flush sequence
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0080, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    check_val("mr_flush", {31'd0, flush_o[0]}, 32'd0);
    check_val("mr_taken", {31'd0, taken_o[0]}, 32'd0);
    check_val("mr_count", {16'd0, bc_o[0]}, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_1234, 1'b1);
    check_val("mr_new_taken", {31'd0, taken_o[0]}, 32'd1);
    check_val("mr_new_addr",  addr_o[0], 32'h0000_1234);
    check_val("mr_new_count", {16'd0, bc_o[0]}, 32'd1);

    // randomized traffic, every cycle compared against the model
    for (int k = 0; k < 3000; k++) begin
      cyc(($urandom_range(63) != 0), ($urandom_range(1) == 1),
          ($urandom_range(9) < 3), ($urandom_range(9) < 3), $urandom, 1'b1);
    end

    // stall counter saturation (bounded)
    sat_extra = 0;
    for (int k = 0; k < 70000 && sat_extra < 4; k++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
      if (m_sc[0] == 65535) sat_extra++;
    end
    check_val("sat_reached", {31'd0, (m_sc[0] == 65535)}, 32'd1);
    check_val("sat_stall", {16'd0, sc_o[0]}, 32'h0000_FFFF);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, ($urandom_range(1) == 1), ($urandom_range(9) < 3),
          ($urandom_range(9) < 4), $urandom, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_ctrl.md
# if_ctrl

Pipeline front-end controller that sequences the IF stage. It merges hazard and memory-stall requests, captures branch resolutions from EXE, and drives the IF stage's `freeze`, `flush`, `branchTaken` and `branchAddr` inputs. It also holds a redirect pending across memory stalls, keeps flush asserted for a fixed number of wrong-path cycles, and exposes two performance counters. It sits between the ID/EXE/MEM stall sources and the IF stage top.

## Interface
- `FLUSH_CYCLES`, default 2: number of unfrozen cycles `flush` stays high per redirect. Legal range 1..15.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset, synchronous and active-low (rst=0 resets on the next rising edge).
- `hazard` input 1: ID-stage data hazard, level.
- `mem_busy` input 1: memory-stage stall, level.
- `exe_branch_taken` input 1: branch resolved taken in EXE.
- `exe_branch_addr` input 32: target for `exe_branch_taken`.
- `freeze` output 1: IF stall, combinational.
- `flush` output 1: IF/ID flush, from state.
- `branchTaken` output 1: IF PC redirect, from state.
- `branchAddr` output 32: redirect target, registered.
- `stall_cycles` output 16: count of cycles with `freeze`=1, saturating.
- `branch_count` output 16: count of redirects issued, wrapping.

## Operation
- States: RUN, HOLD, REDIRECT, FLUSH. A 4-bit flush counter `fcnt` is kept.
- Outputs:
  - `branchTaken` = (state==REDIRECT).
  - `flush` = (state==REDIRECT or FLUSH).
  - `freeze` = `mem_busy` | (`hazard` & ~`flush`). A hazard is ignored while flushing; `mem_busy` always freezes.
- RUN:
  - `exe_branch_taken`=1 and `mem_busy`=0 -> REDIRECT. Capture `exe_branch_addr` into `branchAddr`, load `fcnt`=FLUSH_CYCLES.
  - `exe_branch_taken`=1 and `mem_busy`=1 -> HOLD, with the same capture.
  - Otherwise stay in RUN.
- HOLD:
  - `mem_busy`=0 -> REDIRECT.
  - Otherwise stay. `exe_branch_taken` is ignored, because EXE is frozen and re-presents the same branch.
- REDIRECT:
  - `mem_busy`=1 -> stay, with `branchTaken` held at 1.
  - `mem_busy`=0 -> `fcnt`--. If `fcnt` was 1, go to RUN; else go to FLUSH.
- FLUSH:
  - `mem_busy`=1 -> stay, `fcnt` unchanged.
  - `mem_busy`=0 -> `fcnt`--. If `fcnt` was 1, go to RUN.
- `exe_branch_taken` is sampled only in RUN. In the other states the branch is older-path or wrong-path and is discarded.
- `branchAddr` holds its last captured value outside REDIRECT and changes only on capture.
- Counters:
  - `stall_cycles` increments on every edge where `freeze`=1 and sticks at 0xFFFF.
  - `branch_count` increments on every HOLD->REDIRECT or RUN->REDIRECT transition and wraps 0xFFFF->0.
- Reset (rst=0 at an edge, in any state, including mid-FLUSH or HOLD):
  - State -> RUN, `fcnt`=0, `branchAddr`=0, both counters=0.
  - `flush`=0 and `branchTaken`=0 from the following cycle.
  - `freeze` still follows the inputs combinationally.

## Timing
- Branch sampled at edge N with `mem_busy`=0:
  - `branchTaken`=1 and `flush`=1 in cycle N+1.
  - `flush` remains 1 through cycle N+FLUSH_CYCLES.
  - RUN from cycle N+FLUSH_CYCLES+1, provided no stall intervenes.
- Each cycle with `mem_busy`=1 in HOLD, REDIRECT or FLUSH extends the sequence by exactly one cycle.
- `freeze` has zero latency from `hazard` and `mem_busy`.
- Counter outputs reflect edges up to and including the last edge (one-cycle visibility lag).
- FLUSH_CYCLES=1: REDIRECT goes directly to RUN and FLUSH is never entered.

## Test plan
- Reset: rst=0 for 2 cycles with random inputs -> `flush`=0, `branchTaken`=0, `branchAddr`=0, `stall_cycles`=0, `branch_count`=0. Then rst=1.
- Plain branch, FLUSH_CYCLES=2: `exe_branch_taken`=1 with `exe_branch_addr`=0x00000008 for one cycle at edge N ->
  - N+1: `branchTaken`=1, `branchAddr`=0x08, `flush`=1.
  - N+2: `branchTaken`=0, `flush`=1.
  - N+3: `flush`=0.
  - `branch_count`=1.
- Branch under stall: `mem_busy`=1 for 3 cycles starting at the branch edge ->
  - `branchTaken`=0 and `freeze`=1 for 3 cycles.
  - `branchTaken`=1 in the cycle after `mem_busy` falls.
  - `mem_busy` re-asserted during REDIRECT keeps `branchTaken`=1 until it drops.
- Hazard masking:
  - `hazard`=1 in RUN -> `freeze`=1 in the same cycle.
  - `hazard`=1 during FLUSH -> `freeze`=0.
  - `hazard`=1 with `mem_busy`=1 during FLUSH -> `freeze`=1 and `fcnt` held.
- Counter limits:
  - `mem_busy`=1 for 70000 cycles -> `stall_cycles`=0xFFFF.
  - 65537 redirects -> `branch_count`=0x0001.
- Reset mid-sequence: rst=0 at the second FLUSH cycle -> next cycle `flush`=0 and state RUN. A fresh branch afterwards redirects normally with `branch_count`=1.
